// File: rtl/ones_pattern_gen.sv
// ones_pattern_gen: builds a DATA_WIDTH-bit word containing exactly k set bits,
// one bit position per clock, either packed into the low bits (thermometer
// code) or spread evenly across the word.
// Optional macro ONES_PATTERN_GEN_SELFCHECK_EN adds a chk_fail output that
// flags a built word whose ones count differs from the requested count.
module ones_pattern_gen #(
   parameter  int DATA_WIDTH = 16,
   localparam int CW         = $clog2(DATA_WIDTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [CW-1:0]         in_count,
   input  logic                  in_mode,
   output logic                  bit_out,
   output logic                  bit_valid,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] dout,
`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
   output logic                  chk_fail,
`endif
   output logic                  err
);

   localparam int              IW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]   LP_WIDTH = CW'(DATA_WIDTH);
   localparam logic [IW-1:0]   LP_LAST  = IW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUILD, S_DONE} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic [CW-1:0]         r_k;
   logic                  r_mode;
   logic                  r_err;
   logic [IW-1:0]         r_idx;
   logic [CW-1:0]         r_acc;
   logic [DATA_WIDTH-1:0] r_dout;

   logic                  w_accept;
   logic                  w_last;
   logic                  w_bit;
   logic [CW:0]           w_sum;
   logic [CW-1:0]         w_acc_next;

   assign w_accept = in_valid && (r_state == S_IDLE);
   assign w_last   = (r_state == S_BUILD) && (r_idx == LP_LAST);

   // Bit for the current position: compare against k when packed; when spread,
   // emit a one each time the running sum of k wraps past DATA_WIDTH.
   always_comb begin
      w_sum      = {1'b0, r_acc} + {1'b0, r_k};
      w_bit      = 1'b0;
      w_acc_next = r_acc;
      if (r_mode) begin
         if (w_sum >= {1'b0, LP_WIDTH}) begin
            w_bit      = 1'b1;
            w_acc_next = CW'(w_sum - {1'b0, LP_WIDTH});
         end else begin
            w_acc_next = w_sum[CW-1:0];
         end
      end else begin
         w_bit = ({1'b0, r_idx} < r_k);
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_next = S_BUILD;
         S_BUILD: if (w_last)    w_state_next = S_DONE;
         S_DONE:  if (out_ready) w_state_next = S_IDLE;
         default:                w_state_next = S_IDLE;
      endcase
   end

   // Handshake and serial-bit outputs decoded from the state
   always_comb begin
      in_ready  = (r_state == S_IDLE);
      bit_valid = (r_state == S_BUILD);
      out_valid = (r_state == S_DONE);
      bit_out   = (r_state == S_BUILD) ? w_bit : 1'b0;
   end

   // Request capture (with count saturation) and word assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         r_k    <= '0;
         r_mode <= 1'b0;
         r_err  <= 1'b0;
         r_idx  <= '0;
         r_acc  <= '0;
         r_dout <= '0;
      end else if (w_accept) begin
         r_k    <= (in_count > LP_WIDTH) ? LP_WIDTH : in_count;
         r_mode <= in_mode;
         r_err  <= (in_count > LP_WIDTH);
         r_idx  <= '0;
         r_acc  <= '0;
         r_dout <= '0;
      end else if (r_state == S_BUILD) begin
         r_dout[r_idx] <= w_bit;
         r_idx         <= r_idx + IW'(1);
         r_acc         <= w_acc_next;
      end
   end

   assign dout = r_dout;
   assign err  = r_err;

`ifdef ONES_PATTERN_GEN_SELFCHECK_EN
   logic [CW-1:0] r_ones;
   logic          r_chk_fail;
   logic [CW-1:0] w_ones_next;

   assign w_ones_next = r_ones + CW'(w_bit);

   // Count emitted ones and compare with k as the last position is written
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ones     <= '0;
         r_chk_fail <= 1'b0;
      end else if (w_accept) begin
         r_ones     <= '0;
         r_chk_fail <= 1'b0;
      end else if (r_state == S_BUILD) begin
         r_ones <= w_ones_next;
         if (w_last) begin
            r_chk_fail <= (w_ones_next != r_k);
         end
      end
   end

   // Simulation-time alarm when a finished word has the wrong weight
   always_ff @(posedge clk) begin
      if (!rst && w_last) begin
         assert (w_ones_next == r_k);
      end
   end

   assign chk_fail = r_chk_fail;
`endif

endmodule
